// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: default sizing and
// the event FSM state encoding.
package key_conditioner_pkg;

    localparam int P_KEY_DEFAULT           = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_HELD  = 1'b1
    } kcState_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Key/event bundle between the board buttons, the game controller and the
// conditioner. The conditioner uses the slave side.
interface key_conditioner_if
    import key_conditioner_pkg::*;
#(
    parameter int P_KEY = P_KEY_DEFAULT
);
    localparam int CODE_W = (P_KEY > 1) ? $clog2(P_KEY) : 1;

    logic [P_KEY-1:0]  KEY;
    logic              enable;
    logic [P_KEY-1:0]  keys_db;
    logic              press_valid;
    logic [CODE_W-1:0] press_code;
    logic              multi_error;

    modport master (
        output KEY,
        output enable,
        input  keys_db,
        input  press_valid,
        input  press_code,
        input  multi_error
    );

    modport slave (
        input  KEY,
        input  enable,
        output keys_db,
        output press_valid,
        output press_code,
        output multi_error
    );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer followed by a stability counter that
// only lets a new level through after DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_keyRaw,
    output logic o_stable
);
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_count;

    // Released level is 1, so reset looks like "no button pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_keyRaw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b1;
            r_count  <= '0;
        end else if (r_sync2 == r_stable) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_count  <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/key_conditioner.sv
// Debounces the board push-buttons and turns single clean presses into
// one-cycle events with a key index; simultaneous presses raise multi_error.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int P_KEY           = P_KEY_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    key_conditioner_if.slave   bus
);
    localparam int CODE_W = (P_KEY > 1) ? $clog2(P_KEY) : 1;

    logic [P_KEY-1:0]  w_stable;
    logic [P_KEY-1:0]  w_keysDb;
    logic              w_anyKey;
    logic              w_multiKey;
    logic [CODE_W-1:0] w_keyIdx;

    kcState_t          r_state;
    kcState_t          w_nextState;
    logic              r_pressValid;
    logic              r_multiError;
    logic [CODE_W-1:0] r_pressCode;
    logic              w_pressValidNext;
    logic              w_multiErrorNext;
    logic [CODE_W-1:0] w_pressCodeNext;

    for (genvar g = 0; g < P_KEY; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (CLOCK_50),
            .rst_n    (reset),
            .i_keyRaw (bus.KEY[g]),
            .o_stable (w_stable[g])
        );
    end

    assign w_keysDb   = ~w_stable;
    assign w_anyKey   = |w_keysDb;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multiKey = |(w_keysDb & (w_keysDb - P_KEY'(1)));

    always_comb begin
        w_keyIdx = '0;
        for (int i = 0; i < P_KEY; i++) begin
            if (w_keysDb[i]) begin
                w_keyIdx = CODE_W'(i);
            end
        end
    end

    always_comb begin
        w_nextState      = r_state;
        w_pressValidNext = 1'b0;
        w_multiErrorNext = 1'b0;
        w_pressCodeNext  = r_pressCode;
        case (r_state)
            ST_ARMED: begin
                if (w_multiKey) begin
                    w_multiErrorNext = 1'b1;
                    w_nextState      = ST_HELD;
                end else if (w_anyKey) begin
                    w_nextState = ST_HELD;
                    if (bus.enable) begin
                        w_pressValidNext = 1'b1;
                        w_pressCodeNext  = w_keyIdx;
                    end
                end
            end
            ST_HELD: begin
                if (!w_anyKey) begin
                    w_nextState = ST_ARMED;
                end
            end
            default: w_nextState = ST_ARMED;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_ARMED;
            r_pressValid <= 1'b0;
            r_multiError <= 1'b0;
            r_pressCode  <= '0;
        end else begin
            r_state      <= w_nextState;
            r_pressValid <= w_pressValidNext;
            r_multiError <= w_multiErrorNext;
            r_pressCode  <= w_pressCodeNext;
        end
    end

    assign bus.keys_db     = w_keysDb;
    assign bus.press_valid = r_pressValid;
    assign bus.multi_error = r_multiError;
    assign bus.press_code  = r_pressCode;

endmodule
